// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory front-end of the multi-cycle core:
//   state_e : controller state encoding (IDLE, BUSY, ERR)
//   CNT_W   : width of the BUSY-cycle timeout counter
package mem_ctrl_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter
// Counts BUSY cycles of one memory transaction and flags the cycle that
// would be the TIMEOUT-th one without a completion.
// Ports:
//   clk    in  : clock
//   reset  in  : synchronous, active-low
//   clr    in  : zero the count (priority over en)
//   en     in  : count this cycle (one BUSY cycle)
//   hit    out : en is high and this is the TIMEOUT-th enabled cycle
module mem_timeout_counter
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    // The count equals the number of BUSY cycles already completed, so the
    // current cycle is the TIMEOUT-th one when the count is TIMEOUT-1.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = en && (count == LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Memory front-end between the core's control FSM and a variable-latency
// unified memory. Converts single-cycle mem_read/mem_write strobes into a
// held req/ready transaction, captures IR and MDR, and stalls the FSM until
// the access completes.
//
// Handshake: mem_req is high exactly while in BUSY; mem_addr, mem_we and
// mem_din are stable for the whole time mem_req is high. A transfer
// completes in any BUSY cycle where mem_ready is high. mem_ready is ignored
// outside BUSY.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to turn a misaligned access
// (selected address bits [1:0] non-zero) into an immediate bus error with
// no request issued.
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   mem_read, mem_write : commands from the control FSM (write wins)
//   i_or_d              : address select, 0 = pc, 1 = alu_out
//   IR_write            : a completed fetch updates ir
//   pc, alu_out, wdata  : fetch address, data address, store data
//   mem_req, mem_we     : memory request / write enable
//   mem_addr, mem_din   : memory address / write data
//   mem_ready, mem_dout : memory completion / read data
//   ir, mdr             : instruction and memory data registers
//   stall               : FSM and datapath must hold
//   bus_err             : sticky error (timeout or misalignment)
//   dbg_state           : current controller state
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            i_or_d,
    input  logic            IR_write,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_din,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_dout,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] mdr,
    output logic            stall,
    output logic            bus_err,
    output state_e          dbg_state
);

    state_e          state, next_state;
    logic            cmd;
    logic [XLEN-1:0] sel_addr;
    logic            start;
    logic            complete;
    logic            hit;

    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_din;
    logic            req_we;
    logic            req_to_ir;
    logic            aborted;

    assign cmd      = mem_read | mem_write;
    assign sel_addr = i_or_d ? alu_out : pc;

    mem_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .reset(reset),
        .clr  (state == IDLE),
        .en   (state == BUSY),
        .hit  (hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd) begin
`ifdef MEM_ALIGN_CHECK_EN
                    if (sel_addr[1:0] != 2'b00) begin
                        next_state = ERR;
                    end else begin
                        next_state = BUSY;
                        start      = 1'b1;
                    end
`else
                    next_state = BUSY;
                    start      = 1'b1;
`endif
                end
            end
            BUSY: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mem_ready) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end else if (hit) begin
                    next_state = ERR;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request registers, abort tracking and result capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_addr  <= '0;
            req_din   <= '0;
            req_we    <= 1'b0;
            req_to_ir <= 1'b0;
            aborted   <= 1'b0;
            ir        <= '0;
            mdr       <= '0;
        end else begin
            if (start) begin
                req_addr  <= sel_addr;
                req_din   <= wdata;
                req_we    <= mem_write;
                req_to_ir <= IR_write & ~i_or_d;
                aborted   <= 1'b0;
            end else if ((state == BUSY) && !cmd) begin
                // Once the command has been withdrawn the transfer still runs
                // to completion, but its data is never captured.
                aborted <= 1'b1;
            end

            if (complete && cmd && !aborted && !req_we) begin
                if (req_to_ir) begin
                    ir <= mem_dout;
                end else begin
                    mdr <= mem_dout;
                end
            end
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_we    = req_we;
    assign mem_addr  = req_addr;
    assign mem_din   = req_din;
    assign bus_err   = (state == ERR);
    assign stall     = (cmd & ~((state == BUSY) & mem_ready)) | (state == ERR);
    assign dbg_state = state;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Handshaking memory front-end for the multi-cycle RISC-V core, sitting directly downstream of the control FSM. It turns the FSM's single-cycle `mem_read` / `mem_write` / `i_or_d` / `IR_write` strobes into a req/ready transaction on a variable-latency unified memory. It captures the instruction register (IR) and memory data register (MDR). It asserts `stall` so the FSM holds its state until the access completes.

## Interface
- `XLEN`, default 32: address/data width.
- `TIMEOUT`, default 255: maximum BUSY cycles before a bus error; legal range 1..65535.
- `clk` in 1: the only clock. One clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low.
- `mem_read` in 1: read command from the control FSM.
- `mem_write` in 1: write command from the control FSM.
- `i_or_d` in 1: address select; 0 = `pc`, 1 = `alu_out`.
- `IR_write` in 1: a completed read updates `ir`.
- `pc` in XLEN: fetch address.
- `alu_out` in XLEN: data address.
- `wdata` in XLEN: store data (B register).
- `mem_req` out 1: request to memory.
- `mem_we` out 1: 1 = write.
- `mem_addr` out XLEN: memory address.
- `mem_din` out XLEN: write data to memory.
- `mem_ready` in 1: memory completion.
- `mem_dout` in XLEN: read data from memory.
- `ir` out XLEN: instruction register.
- `mdr` out XLEN: memory data register.
- `stall` out 1: the FSM and datapath must not advance; gates `PC_write` and `reg_write`.
- `bus_err` out 1: sticky error flag.

## Operation
- `cmd` = `mem_read | mem_write`. If both are set, the access is a write.
- States: IDLE, BUSY, ERR.
- **IDLE**
  - When `cmd`=1: latch address, `wdata` and `we` into request registers, then go to BUSY.
  - Address latched is `alu_out` if `i_or_d`=1, else `pc`.
- **BUSY**
  - `mem_req`=1; `mem_addr`, `mem_we` and `mem_din` come from the request registers and stay stable.
  - On `mem_ready`=1, return to IDLE.
  - On a read completion: `ir <= mem_dout` if the latched `IR_write`=1 and `i_or_d`=0; otherwise `mdr <= mem_dout`.
  - A write completion updates neither register.
- **Abort**: if `cmd` drops while in BUSY, the request is still held until `mem_ready`, and the result is discarded (no `ir`/`mdr` update).
- **Timeout**: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle. When it reaches `TIMEOUT` with no `mem_ready`, go to ERR.
- **ERR**: `mem_req`=0, `bus_err`=1, `stall`=1. The block stays in ERR until reset.
- **stall** (combinational) = (`cmd` & !(BUSY & `mem_ready`)) | ERR.
- A new `cmd` in the cycle immediately after completion starts a new transaction. There is no mandatory idle gap.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `bus_err` = 0; `mem_addr`, `mem_din`, `ir`, `mdr` = 0; counter = 0.
- Reset mid-transaction abandons the request; `mem_req` falls on the next edge.
- Minimum access time is 2 cycles: the command cycle in IDLE (`stall`=1), then the BUSY cycle with `mem_ready`=1 (`stall`=0).
- Memory latency L cycles gives an access time of 1+L cycles.
- `ir`/`mdr` are valid in the cycle after `stall` falls.
- `mem_ready` is ignored outside BUSY.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A data access (`i_or_d`=1) with `alu_out[1:0]`≠0, or a fetch with `pc[1:0]`≠0, goes straight from IDLE to ERR.
  - No request is issued; `bus_err`=1.
- Undefined: no alignment check. The address is passed through unmodified.

## Structure
- Shared package `mem_ctrl_pkg`: state enum (IDLE=2'd0, BUSY=2'd1, ERR=2'd2) and the counter width constant (16).
- Sub-module `mem_timeout_counter`: clear/enable/`hit` output, compared against `TIMEOUT`.
- Everything else stays in `mem_access_ctrl`.

## Test plan
- **Fetch, L=1**: `mem_read`=1, `IR_write`=1, `i_or_d`=0, `pc`=0x40, memory returns 0x00500093 → `mem_addr`=0x40, `stall` 1 then 0, `ir`=0x00500093, `mdr` unchanged.
- **Load, L=4**: `i_or_d`=1, `alu_out`=0x100, data 0xDEADBEEF → `stall` held for 4 cycles, `mdr`=0xDEADBEEF on the 5th edge, `ir` unchanged.
- **Store**: `mem_write`=1, `alu_out`=0x104, `wdata`=0x12345678 → `mem_we`=1, `mem_din`=0x12345678 held until `mem_ready`; `ir`/`mdr` unchanged.
- **Timeout**: `TIMEOUT`=8, `mem_ready` never asserted → ERR after 8 BUSY cycles, `bus_err`=1, `mem_req`=0, `stall` stuck at 1. `reset` low for 1 cycle → all outputs return to 0.
- **Reset mid-BUSY, then back-to-back**: reset during BUSY → `mem_req`=0 next cycle. Then two reads issued back-to-back at L=1 complete in 4 cycles total.
- **Alignment**: with `MEM_ALIGN_CHECK_EN`, `alu_out`=0x102 load → `bus_err`=1 and no `mem_req` ever rises. Without the macro → normal access to 0x102.
